ntt_loop_ctrl: RTL



---
 rtl/otbn_pq_pkg.sv | 33 +++
 rtl/ntt_loop_ctrl_if.sv | 35 +++
 rtl/ntt_loop_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/otbn_pq_pkg.sv
// rtl/otbn_pq_pkg.sv - Shared types for the OTBN-PQ NTT loop sequencer
package otbn_pq_pkg;

  // IsprM sits at code 0 so the idle value of the address bus is all-zero.
  typedef enum logic [1:0] {
    IsprM    = 2'd0,
    IsprJ2   = 2'd1,
    IsprJ    = 2'd2,
    IsprMode = 2'd3
  } ipqspr_e;

  localparam logic NttModeFwd = 1'b0;
  localparam logic NttModeInv = 1'b1;

  typedef enum logic [3:0] {
    NttIdle,
    NttInit,
    NttCfgMode,
    NttCfgM,
    NttCfgJ2,
    NttSet,
    NttBfly,
    NttGrp,
    NttStg,
    NttClrJ,
    NttDone
  } ntt_state_e;

  function automatic logic [7:0] ntt_half_n(int unsigned log_n);
    return 8'(32'd1 << (log_n - 1));
  endfunction

endpackage

// File: rtl/ntt_loop_ctrl_if.sv
// rtl/ntt_loop_ctrl_if.sv - Decoder, address-unit and butterfly-ALU signals of the NTT sequencer
interface ntt_loop_ctrl_if;
  import otbn_pq_pkg::*;

  logic        start_i;
  logic        mode_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic        bf_valid_o;
  logic        bf_ready_i;
  logic        ispr_init_o;
  logic        ispr_we_o;
  ipqspr_e     ispr_addr_o;
  logic [31:0] ispr_wdata_o;
  logic        set_idx_o;
  logic        inc_idx_o;
  logic        inc_j_o;
  logic        sl_m_o;
  logic        sl_j2_o;

  // master is the sequencer; slave is the decoder/address-unit/ALU side.
  modport master (
    input  start_i, mode_i, abort_i, bf_ready_i,
    output busy_o, done_o, bf_valid_o, ispr_init_o, ispr_we_o, ispr_addr_o,
           ispr_wdata_o, set_idx_o, inc_idx_o, inc_j_o, sl_m_o, sl_j2_o
  );

  modport slave (
    output start_i, mode_i, abort_i, bf_ready_i,
    input  busy_o, done_o, bf_valid_o, ispr_init_o, ispr_we_o, ispr_addr_o,
           ispr_wdata_o, set_idx_o, inc_idx_o, inc_j_o, sl_m_o, sl_j2_o
  );

endinterface

// File: rtl/ntt_loop_ctrl.sv
// rtl/ntt_loop_ctrl.sv - NTT/INTT loop-nest sequencer driving the PQ address unit and butterfly ALU
module ntt_loop_ctrl
  import otbn_pq_pkg::*;
#(
  parameter int unsigned LOG_N = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  ntt_loop_ctrl_if.master bus
);

  localparam logic [7:0] HalfN     = ntt_half_n(LOG_N);
  localparam logic [2:0] LastStage = 3'(LOG_N - 1);

  ntt_state_e state_q, state_d;
  logic       mode_q, mode_d;
  logic [2:0] stage_q, stage_d;
  logic [7:0] grp_q, grp_d;
  logic [7:0] bf_q, bf_d;
  logic [7:0] bpg_q, bpg_d;
  logic [7:0] ngrp_q, ngrp_d;

  logic fwd;
  logic live;
  logic last_bf;
  logic last_grp;
  logic last_stage;

  assign fwd        = (mode_q == NttModeFwd);
  assign live       = !bus.abort_i;
  assign last_bf    = (bf_q == bpg_q - 8'd1);
  assign last_grp   = (grp_q == ngrp_q - 8'd1);
  assign last_stage = (stage_q == LastStage);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    stage_d = stage_q;
    grp_d   = grp_q;
    bf_d    = bf_q;
    bpg_d   = bpg_q;
    ngrp_d  = ngrp_q;
    if (bus.abort_i) begin
      state_d = NttIdle;
    end else begin
      case (state_q)
        NttIdle: begin
          if (bus.start_i) begin
            state_d = NttInit;
            mode_d  = bus.mode_i;
            stage_d = 3'd0;
            grp_d   = 8'd0;
            bf_d    = 8'd0;
            bpg_d   = (bus.mode_i == NttModeFwd) ? HalfN : 8'd1;
            ngrp_d  = (bus.mode_i == NttModeFwd) ? 8'd1 : HalfN;
          end
        end
        NttInit:    state_d = NttCfgMode;
        NttCfgMode: state_d = NttCfgM;
        NttCfgM:    state_d = NttCfgJ2;
        NttCfgJ2:   state_d = NttSet;
        NttSet:     state_d = NttBfly;
        NttBfly: begin
          if (bus.bf_ready_i) begin
            if (last_bf) begin
              bf_d    = 8'd0;
              state_d = NttGrp;
            end else begin
              bf_d = bf_q + 8'd1;
            end
          end
        end
        NttGrp: begin
          if (last_grp) begin
            state_d = NttStg;
          end else begin
            grp_d   = grp_q + 8'd1;
            state_d = NttSet;
          end
        end
        NttStg: begin
          if (last_stage) begin
            state_d = NttDone;
          end else begin
            stage_d = stage_q + 3'd1;
            grp_d   = 8'd0;
            // Forward halves the butterfly span each stage, inverse doubles it.
            bpg_d   = fwd ? (bpg_q >> 1) : (bpg_q << 1);
            ngrp_d  = fwd ? (ngrp_q << 1) : (ngrp_q >> 1);
            state_d = NttClrJ;
          end
        end
        NttClrJ: state_d = NttSet;
        NttDone: state_d = NttIdle;
        default: state_d = NttIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= NttIdle;
      mode_q  <= NttModeFwd;
      stage_q <= 3'd0;
      grp_q   <= 8'd0;
      bf_q    <= 8'd0;
      bpg_q   <= 8'd0;
      ngrp_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      stage_q <= stage_d;
      grp_q   <= grp_d;
      bf_q    <= bf_d;
      bpg_q   <= bpg_d;
      ngrp_q  <= ngrp_d;
    end
  end

  // Every strobe is masked by abort so the address unit is left untouched.
  always_comb begin
    bus.busy_o       = (state_q != NttIdle);
    bus.done_o       = live && (state_q == NttDone);
    bus.bf_valid_o   = live && (state_q == NttBfly);
    bus.inc_idx_o    = live && (state_q == NttBfly) && bus.bf_ready_i && !last_bf;
    bus.ispr_init_o  = live && (state_q == NttInit);
    bus.set_idx_o    = live && (state_q == NttSet);
    bus.inc_j_o      = live && (state_q == NttGrp);
    bus.sl_m_o       = live && (state_q == NttStg) && !last_stage;
    bus.sl_j2_o      = live && (state_q == NttStg) && !last_stage;
    bus.ispr_we_o    = live && ((state_q == NttCfgMode) || (state_q == NttCfgM) ||
                                (state_q == NttCfgJ2)   || (state_q == NttClrJ));
    bus.ispr_addr_o  = IsprM;
    bus.ispr_wdata_o = 32'd0;
    case (state_q)
      NttCfgMode: begin
        bus.ispr_addr_o  = IsprMode;
        bus.ispr_wdata_o = {31'd0, mode_q};
      end
      NttCfgM: bus.ispr_wdata_o = {24'd0, fwd ? HalfN : 8'd1};
      NttCfgJ2: begin
        bus.ispr_addr_o  = IsprJ2;
        bus.ispr_wdata_o = {24'd0, fwd ? 8'd1 : HalfN};
      end
      NttClrJ: bus.ispr_addr_o = IsprJ;
      default: ;
    endcase
  end

endmodule
